operand_unpacker: RTL

OPERAND_UNPACKER -- requirements
Module: operand_unpacker

---
 rtl/fp_pkg.sv | 27 ++
 rtl/operand_unpacker_if.sv | 21 ++
 rtl/fp_classify.sv | 39 +++
 rtl/operand_unpacker.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision field widths, rounding-mode encodings and operand class flags
// used by the unpack and rounding stages.
package fp_pkg;

  localparam int unsigned FP_XLEN   = 32;
  localparam int unsigned FP_EXP_W  = 8;
  localparam int unsigned FP_MANT_W = 23;
  localparam int unsigned FP_RM_W   = 3;

  localparam logic [FP_RM_W-1:0] PARM_RM_RNE = 3'b000;
  localparam logic [FP_RM_W-1:0] PARM_RM_RTZ = 3'b001;
  localparam logic [FP_RM_W-1:0] PARM_RM_RDN = 3'b010;
  localparam logic [FP_RM_W-1:0] PARM_RM_RUP = 3'b011;
  localparam logic [FP_RM_W-1:0] PARM_RM_RMM = 3'b100;

  // Canonical quiet-NaN fraction emitted downstream when an operation is invalid
  localparam logic [FP_MANT_W-1:0] PARM_MANT_NAN = 23'h400000;

  typedef struct packed {
    logic den;
    logic inf;
    logic zero;
    logic nan;
    logic snan;
  } fp_class_t;

endpackage

// File: rtl/operand_unpacker_if.sv
// Upstream operand-set handshake bundle feeding the operand unpacker.
interface operand_unpacker_if
  import fp_pkg::*;
#(
  parameter int unsigned XLEN = FP_XLEN,
  parameter int unsigned RM_W = FP_RM_W
);

  logic            valid;
  logic            ready;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [XLEN-1:0] c;
  logic            sub;
  logic [RM_W-1:0] rm;
  logic            flush;

  modport master (output valid, a, b, c, sub, rm, flush, input ready);
  modport slave  (input valid, a, b, c, sub, rm, flush, output ready);

endinterface

// File: rtl/fp_classify.sv
// Combinational field extraction and IEEE-754 class decode of one packed operand.
module fp_classify
  import fp_pkg::*;
#(
  parameter int unsigned PARM_EXP  = FP_EXP_W,
  parameter int unsigned PARM_MANT = FP_MANT_W
) (
  input  logic [PARM_EXP+PARM_MANT:0] op_i,
  output logic                        sign_c,
  output logic [PARM_EXP-1:0]         exp_raw_c,
  output logic [PARM_MANT:0]          mant_c,
  output fp_class_t                   cls_c
);

  logic [PARM_EXP-1:0]  exp_f;
  logic [PARM_MANT-1:0] frac_f;
  logic                 exp_ones;
  logic                 exp_zero;
  logic                 frac_zero;

  always_comb begin
    exp_f     = op_i[PARM_MANT +: PARM_EXP];
    frac_f    = op_i[PARM_MANT-1:0];
    exp_ones  = &exp_f;
    exp_zero  = ~|exp_f;
    frac_zero = ~|frac_f;

    sign_c         = op_i[PARM_EXP+PARM_MANT];
    cls_c.inf      = exp_ones & frac_zero;
    cls_c.nan      = exp_ones & ~frac_zero;
    cls_c.snan     = exp_ones & ~frac_zero & ~frac_f[PARM_MANT-1];
    cls_c.zero     = exp_zero & frac_zero;
    cls_c.den      = exp_zero & ~frac_zero;
    // Denormals share the exponent of the smallest normal, hidden bit cleared
    exp_raw_c      = cls_c.den ? PARM_EXP'(1) : exp_f;
    mant_c         = {~exp_zero, frac_f};
  end

endmodule

// File: rtl/operand_unpacker.sv
// Two-stage FMA front end: registers A/B/C, classifies each operand and derives the
// effective product sign and early invalid-operation flag for the datapath.
module operand_unpacker
  import fp_pkg::*;
#(
  parameter int unsigned PARM_XLEN = FP_XLEN,
  parameter int unsigned PARM_EXP  = FP_EXP_W,
  parameter int unsigned PARM_MANT = FP_MANT_W,
  parameter int unsigned PARM_RM   = FP_RM_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,

  input  logic                 Valid_i,
  output logic                 Ready_o,
  input  logic [PARM_XLEN-1:0] A_i,
  input  logic [PARM_XLEN-1:0] B_i,
  input  logic [PARM_XLEN-1:0] C_i,
  input  logic                 Sub_i,
  input  logic [PARM_RM-1:0]   Rounding_mode_i,
  input  logic                 Flush_i,

  output logic                 Valid_o,
  input  logic                 Ready_i,

  output logic                 A_Sign_o,
  output logic [PARM_EXP-1:0]  A_Exp_raw_o,
  output logic [PARM_MANT:0]   A_Mant_o,
  output logic                 A_DeN_o,
  output logic                 A_Inf_o,
  output logic                 A_Zero_o,
  output logic                 A_NaN_o,
  output logic                 A_SNaN_o,

  output logic                 B_Sign_o,
  output logic [PARM_EXP-1:0]  B_Exp_raw_o,
  output logic [PARM_MANT:0]   B_Mant_o,
  output logic                 B_DeN_o,
  output logic                 B_Inf_o,
  output logic                 B_Zero_o,
  output logic                 B_NaN_o,
  output logic                 B_SNaN_o,

  output logic                 C_Sign_o,
  output logic [PARM_EXP-1:0]  C_Exp_raw_o,
  output logic [PARM_MANT:0]   C_Mant_o,
  output logic                 C_DeN_o,
  output logic                 C_Inf_o,
  output logic                 C_Zero_o,
  output logic                 C_NaN_o,
  output logic                 C_SNaN_o,

  output logic                 Sub_Sign_o,
  output logic [PARM_RM-1:0]   Rounding_mode_o,
  output logic                 Invalid_pre_o
);

  localparam int unsigned N_OPS = 3;

  // Stage 1: raw operand set
  logic [N_OPS-1:0][PARM_XLEN-1:0] op_q, op_d;
  logic                            sub_q, sub_d;
  logic [PARM_RM-1:0]              rm_s1_q, rm_s1_d;
  logic                            s1_valid_q, s1_valid_d;

  // Stage 2: classified operand set
  logic [N_OPS-1:0]                sign_q, sign_d;
  logic [N_OPS-1:0][PARM_EXP-1:0]  exp_q, exp_d;
  logic [N_OPS-1:0][PARM_MANT:0]   mant_q, mant_d;
  fp_class_t [N_OPS-1:0]           cls_q, cls_d;
  logic                            sub_sign_q, sub_sign_d;
  logic [PARM_RM-1:0]              rm_s2_q, rm_s2_d;
  logic                            invalid_q, invalid_d;
  logic                            s2_valid_q, s2_valid_d;

  logic [N_OPS-1:0]                cl_sign;
  logic [N_OPS-1:0][PARM_EXP-1:0]  cl_exp;
  logic [N_OPS-1:0][PARM_MANT:0]   cl_mant;
  fp_class_t [N_OPS-1:0]           cl_cls;

  logic s1_advance;
  logic accept;
  logic s1_to_s2;
  logic sub_sign_c;
  logic invalid_c;

  for (genvar g = 0; g < int'(N_OPS); g++) begin : g_classify
    fp_classify #(
      .PARM_EXP  (PARM_EXP),
      .PARM_MANT (PARM_MANT)
    ) u_fp_classify (
      .op_i      (op_q[g]),
      .sign_c    (cl_sign[g]),
      .exp_raw_c (cl_exp[g]),
      .mant_c    (cl_mant[g]),
      .cls_c     (cl_cls[g])
    );
  end

  // Handshake: stage 1 frees up whenever stage 2 can take its content
  always_comb begin
    s1_advance = ~s2_valid_q | Ready_i;
    Ready_o    = ~s1_valid_q | s1_advance;
    accept     = Valid_i & Ready_o;
    s1_to_s2   = s1_valid_q & s1_advance;
  end

  // Effective-operation sign and early invalid detection (sNaN, 0*Inf, Inf-Inf)
  always_comb begin
    sub_sign_c = cl_sign[0] ^ cl_sign[1] ^ cl_sign[2] ^ sub_q;
    invalid_c  = cl_cls[0].snan | cl_cls[1].snan | cl_cls[2].snan
               | (cl_cls[1].zero & cl_cls[2].inf)
               | (cl_cls[1].inf  & cl_cls[2].zero)
               | (sub_sign_c & cl_cls[0].inf & (cl_cls[1].inf | cl_cls[2].inf));
  end

  // Next-state for both stages; flush overrides any same-cycle accept or move
  always_comb begin
    op_d       = op_q;
    sub_d      = sub_q;
    rm_s1_d    = rm_s1_q;
    s1_valid_d = s1_valid_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    mant_d     = mant_q;
    cls_d      = cls_q;
    sub_sign_d = sub_sign_q;
    rm_s2_d    = rm_s2_q;
    invalid_d  = invalid_q;
    s2_valid_d = s2_valid_q;

    if (accept) begin
      op_d    = {C_i, B_i, A_i};
      sub_d   = Sub_i;
      rm_s1_d = Rounding_mode_i;
    end

    if (s1_to_s2) begin
      sign_d     = cl_sign;
      exp_d      = cl_exp;
      mant_d     = cl_mant;
      cls_d      = cl_cls;
      sub_sign_d = sub_sign_c;
      rm_s2_d    = rm_s1_q;
      invalid_d  = invalid_c;
    end

    if (Flush_i) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (accept) begin
        s1_valid_d = 1'b1;
      end else if (s1_advance) begin
        s1_valid_d = 1'b0;
      end
      if (s1_advance) begin
        s2_valid_d = s1_valid_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q       <= '0;
      sub_q      <= 1'b0;
      rm_s1_q    <= PARM_RM'(PARM_RM_RNE);
      s1_valid_q <= 1'b0;
      sign_q     <= '0;
      exp_q      <= '0;
      mant_q     <= '0;
      cls_q      <= '0;
      sub_sign_q <= 1'b0;
      rm_s2_q    <= PARM_RM'(PARM_RM_RNE);
      invalid_q  <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      op_q       <= op_d;
      sub_q      <= sub_d;
      rm_s1_q    <= rm_s1_d;
      s1_valid_q <= s1_valid_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      mant_q     <= mant_d;
      cls_q      <= cls_d;
      sub_sign_q <= sub_sign_d;
      rm_s2_q    <= rm_s2_d;
      invalid_q  <= invalid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  always_comb begin
    Valid_o         = s2_valid_q;

    A_Sign_o        = sign_q[0];
    A_Exp_raw_o     = exp_q[0];
    A_Mant_o        = mant_q[0];
    A_DeN_o         = cls_q[0].den;
    A_Inf_o         = cls_q[0].inf;
    A_Zero_o        = cls_q[0].zero;
    A_NaN_o         = cls_q[0].nan;
    A_SNaN_o        = cls_q[0].snan;

    B_Sign_o        = sign_q[1];
    B_Exp_raw_o     = exp_q[1];
    B_Mant_o        = mant_q[1];
    B_DeN_o         = cls_q[1].den;
    B_Inf_o         = cls_q[1].inf;
    B_Zero_o        = cls_q[1].zero;
    B_NaN_o         = cls_q[1].nan;
    B_SNaN_o        = cls_q[1].snan;

    C_Sign_o        = sign_q[2];
    C_Exp_raw_o     = exp_q[2];
    C_Mant_o        = mant_q[2];
    C_DeN_o         = cls_q[2].den;
    C_Inf_o         = cls_q[2].inf;
    C_Zero_o        = cls_q[2].zero;
    C_NaN_o         = cls_q[2].nan;
    C_SNaN_o        = cls_q[2].snan;

    Sub_Sign_o      = sub_sign_q;
    Rounding_mode_o = rm_s2_q;
    Invalid_pre_o   = invalid_q;
  end

endmodule
